// File: rtl/beat_gen_if.sv
// Beat generator control/status bundle between the tempo source and the sequencer.
// Latency: none (wires only).
// Backpressure: none; beat/bar are strobes that the consumer must take when seen.
//
// Signals:
//   en, sync, period_in, period_load, beats_per_bar : control, driven by master
//   beat, bar, beat_idx, period_pending             : status, driven by slave (beat_gen)
interface beat_gen_if #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned IDX_W = 5
);
  logic             en;
  logic             sync;
  logic [WIDTH-1:0] period_in;
  logic             period_load;
  logic [IDX_W-1:0] beats_per_bar;
  logic             beat;
  logic             bar;
  logic [IDX_W-1:0] beat_idx;
  logic             period_pending;

  modport master (
    output en, sync, period_in, period_load, beats_per_bar,
    input  beat, bar, beat_idx, period_pending
  );

  modport slave (
    input  en, sync, period_in, period_load, beats_per_bar,
    output beat, bar, beat_idx, period_pending
  );
endinterface

// File: rtl/beat_gen.sv
// Programmable beat/tempo generator: one-cycle beat pulse every period, bar/downbeat tracking.
// Latency: all outputs registered; first enabled edge after reset produces beat+bar.
// Backpressure: none; en low freezes the phase, sync restarts it.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : beat_gen_if.slave (control in, beat/bar/beat_idx/period_pending out)
// Optional feature: define BEAT_GEN_SWING_EN to alternate long/short intervals
// (P+P/4 after even beats, P-P/4 after odd beats, P>=4 only).
module beat_gen #(
  parameter int unsigned WIDTH          = 22,
  parameter int unsigned IDX_W          = 5,
  parameter int unsigned DEFAULT_PERIOD = 3125000
) (
  input  logic       clk,
  input  logic       rst,
  beat_gen_if.slave  bus
);

  localparam int unsigned CW = WIDTH + 1;
  localparam int unsigned IW = IDX_W + 1;
  localparam logic [WIDTH-1:0] DEF_PER = WIDTH'(DEFAULT_PERIOD);

  // One bit wider than the period so the swing-lengthened interval fits.
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] per;
  logic [WIDTH-1:0] pend;
  logic             pend_vld;
  logic [IDX_W-1:0] nidx;
  logic [IDX_W-1:0] idx_q;
  logic             beat_q;
  logic             bar_q;

  logic             boundary;
  logic [WIDTH-1:0] next_per;
  logic [CW-1:0]    len;
  logic [CW-1:0]    reload;
  logic [IW-1:0]    nidx_inc;
  logic [IW-1:0]    eff_bpb;
  logic [IDX_W-1:0] nidx_nxt;

  always_comb begin
    boundary = bus.en && !bus.sync && (cnt == '0);
    // A load landing on the boundary itself bypasses the pending register.
    next_per = bus.period_load ? bus.period_in : (pend_vld ? pend : per);
    len      = {1'b0, next_per};
`ifdef BEAT_GEN_SWING_EN
    if (next_per >= WIDTH'(4)) begin
      if (nidx[0]) begin
        len = {1'b0, next_per} - {3'b000, next_per[WIDTH-1:2]};
      end else begin
        len = {1'b0, next_per} + {3'b000, next_per[WIDTH-1:2]};
      end
    end
`endif
    // Periods of 0 and 1 both mean a beat on every enabled cycle.
    if (len == '0) begin
      len = CW'(1);
    end
    reload   = len - CW'(1);
    nidx_inc = {1'b0, nidx} + IW'(1);
    eff_bpb  = (bus.beats_per_bar == '0) ? IW'(1) : {1'b0, bus.beats_per_bar};
    // >= rather than == so a shrinking bar length wraps immediately.
    nidx_nxt = (nidx_inc >= eff_bpb) ? '0 : nidx_inc[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      per      <= DEF_PER;
      pend     <= '0;
      pend_vld <= 1'b0;
      nidx     <= '0;
      idx_q    <= '0;
      beat_q   <= 1'b0;
      bar_q    <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      bar_q  <= 1'b0;
      if (bus.period_load) begin
        pend <= bus.period_in;
      end
      if (bus.sync) begin
        // Next enabled cycle becomes a downbeat; pending period survives.
        cnt  <= '0;
        nidx <= '0;
        if (bus.period_load) begin
          pend_vld <= 1'b1;
        end
      end else if (boundary) begin
        beat_q   <= 1'b1;
        bar_q    <= (nidx == '0);
        idx_q    <= nidx;
        nidx     <= nidx_nxt;
        per      <= next_per;
        pend_vld <= 1'b0;
        cnt      <= reload;
      end else begin
        if (bus.en) begin
          cnt <= cnt - CW'(1);
        end
        if (bus.period_load) begin
          pend_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.beat           = beat_q;
  assign bus.bar            = bar_q;
  assign bus.beat_idx       = idx_q;
  assign bus.period_pending = pend_vld;

endmodule

// File: tb/tb_beat_gen.sv
// Self-checking bench for beat_gen: directed scenarios plus randomized traffic
// compared every cycle against a behavioural tempo model.
module tb_beat_gen;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;
  localparam int DEF   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  beat_gen_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  beat_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W), .DEFAULT_PERIOD(DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef int iq_t[$];

  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;
  iq_t beat_edges, bar_edges, beat_idxs;
  iq_t exp_a, exp_b, exp_c;
  bit  pend_at [0:63];

  // Reference model: cycles left until the next beat, beat numbering within the bar.
  int  m_rem, m_per, m_pend, m_next, m_idx;
  bit  m_pflag, m_beat, m_bar;

  function automatic int interval_of(input int p, input int idx);
`ifdef BEAT_GEN_SWING_EN
    if (p >= 4) return (idx % 2 == 0) ? p + p / 4 : p - p / 4;
`endif
    return (p < 1) ? 1 : p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit s, input bit ld,
                            input int pin, input int bpb);
    int p;
    int bars;
    m_beat = 1'b0;
    m_bar  = 1'b0;
    bars   = (bpb < 1) ? 1 : bpb;
    if (!r) begin
      m_rem = 0; m_per = DEF; m_pend = 0; m_pflag = 1'b0; m_next = 0; m_idx = 0;
    end else if (s) begin
      m_rem  = 0;
      m_next = 0;
      if (ld) begin m_pend = pin; m_pflag = 1'b1; end
    end else if (e && m_rem == 0) begin
      p       = ld ? pin : (m_pflag ? m_pend : m_per);
      m_per   = p;
      m_pflag = 1'b0;
      m_beat  = 1'b1;
      m_idx   = m_next;
      m_bar   = (m_next == 0);
      m_rem   = interval_of(p, m_next) - 1;
      m_next  = (m_next + 1 >= bars) ? 0 : m_next + 1;
    end else begin
      if (e) m_rem--;
      if (ld) begin m_pend = pin; m_pflag = 1'b1; end
    end
  endtask

  task automatic tick();
    bit r, e, s, ld;
    int pin, bpb;
    r = rst; e = bus.en; s = bus.sync; ld = bus.period_load;
    pin = int'(bus.period_in); bpb = int'(bus.beats_per_bar);
    @(posedge clk);
    #1;
    edge_n++;
    model_step(r, e, s, ld, pin, bpb);
    check("beat", {31'd0, bus.beat}, {31'd0, m_beat});
    check("bar", {31'd0, bus.bar}, {31'd0, m_bar});
    check("beat_idx", 32'(bus.beat_idx), 32'(m_idx));
    check("period_pending", {31'd0, bus.period_pending}, {31'd0, m_pflag});
    if (r) begin
      if (bus.beat === 1'b1) begin
        beat_edges.push_back(edge_n);
        beat_idxs.push_back(int'(bus.beat_idx));
      end
      if (bus.bar === 1'b1) bar_edges.push_back(edge_n);
      if (edge_n < 64) pend_at[edge_n] = bus.period_pending;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.en = 1'b1; bus.sync = 1'b0; bus.period_load = 1'b0;
    bus.period_in = '0; bus.beats_per_bar = 3'd4;
    tick();
    tick();
    rst = 1'b1;
    edge_n = 0;
    beat_edges.delete(); bar_edges.delete(); beat_idxs.delete();
    for (int i = 0; i < 64; i++) pend_at[i] = 1'b0;
  endtask

  task automatic cmp_list(input string tag, input iq_t got, input iq_t exp);
    check({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic load_now(input int p);
    bus.period_load = 1'b1;
    bus.period_in   = 8'(p);
    tick();
    bus.period_load = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_beat", {31'd0, bus.beat}, 32'd0);
    check("rst_bar", {31'd0, bus.bar}, 32'd0);
    check("rst_idx", 32'(bus.beat_idx), 32'd0);
    check("rst_pending", {31'd0, bus.period_pending}, 32'd0);

    // Basic timing with the reset period
    repeat (17) tick();
`ifdef BEAT_GEN_SWING_EN
    exp_a = '{1, 6, 9, 14, 17};
`else
    exp_a = '{1, 5, 9, 13, 17};
`endif
    exp_b = '{0, 1, 2, 3, 0};
    exp_c = '{1, 17};
    cmp_list("basic_beats", beat_edges, exp_a);
    cmp_list("basic_idx", beat_idxs, exp_b);
    cmp_list("basic_bars", bar_edges, exp_c);

    // Deferred load: P=8 taken on the first boundary, 5 loaded at edge 3
    do_reset();
    load_now(8);
    tick();
    load_now(5);
    repeat (18) tick();
`ifdef BEAT_GEN_SWING_EN
    exp_a = '{1, 11, 15, 21};
`else
    exp_a = '{1, 9, 14, 19};
`endif
    cmp_list("load_beats", beat_edges, exp_a);
    check("load_pend_e2", {31'd0, pend_at[2]}, 32'd0);
    check("load_pend_e3", {31'd0, pend_at[3]}, 32'd1);
    check("load_pend_e8", {31'd0, pend_at[8]}, 32'd1);
    check("load_pend_e21", {31'd0, pend_at[21]}, 32'd0);

    // Enable gating for edges 3..5
    do_reset();
    tick();
    tick();
    bus.en = 1'b0;
    repeat (3) begin
      tick();
      check("gap_idx", 32'(bus.beat_idx), 32'd0);
      check("gap_beat", {31'd0, bus.beat}, 32'd0);
    end
    bus.en = 1'b1;
    repeat (4) tick();
`ifdef BEAT_GEN_SWING_EN
    exp_a = '{1, 9};
`else
    exp_a = '{1, 8};
`endif
    exp_b = '{0, 1};
    cmp_list("gate_beats", beat_edges, exp_a);
    cmp_list("gate_idx", beat_idxs, exp_b);

    // Sync at edge 12 with a three-beat bar
    do_reset();
    bus.beats_per_bar = 3'd3;
    load_now(8);
    repeat (10) tick();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    repeat (11) tick();
`ifdef BEAT_GEN_SWING_EN
    exp_a = '{1, 11, 13, 23};
`else
    exp_a = '{1, 9, 13, 21};
`endif
    exp_b = '{0, 1, 0, 1};
    exp_c = '{1, 13};
    cmp_list("sync_beats", beat_edges, exp_a);
    cmp_list("sync_idx", beat_idxs, exp_b);
    cmp_list("sync_bars", bar_edges, exp_c);

    // Degenerate period 0 and bar length 0
    do_reset();
    bus.beats_per_bar = 3'd0;
    load_now(0);
    repeat (5) tick();
    exp_a = '{1, 2, 3, 4, 5, 6};
    exp_b = '{0, 0, 0, 0, 0, 0};
    cmp_list("degen_beats", beat_edges, exp_a);
    cmp_list("degen_bars", bar_edges, exp_a);
    cmp_list("degen_idx", beat_idxs, exp_b);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.en          = ($urandom % 8) != 0;
      bus.sync        = ($urandom % 40) == 0;
      bus.period_load = ($urandom % 7) == 0;
      bus.period_in   = 8'($urandom_range(0, 20));
      if (($urandom % 25) == 0) bus.beats_per_bar = 3'($urandom_range(0, 7));
      rst = ($urandom % 300) != 0;
      tick();
    end
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
